// File: rtl/decode_stage.sv
// RISC-V decode stage: register file with writeback bypass, immediate generation,
// and a registered decode-to-execute payload with stall, flush and load-use bubbles.
module decode_stage #(
    parameter int          XLEN      = 32,
    parameter int          NREGS     = 32,
    parameter int          RADDR_W   = $clog2(NREGS),
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    pc_decode,
    input  logic [31:0]        instr_decode,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    pc_exe,
    output logic [31:0]        instr_exe,
    output logic [XLEN-1:0]    rs1_exe,
    output logic [XLEN-1:0]    rs2_exe,
    output logic [RADDR_W-1:0] rd_exe,
    output logic [XLEN-1:0]    imm_exe
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0]    rf_q [NREGS];
    logic [RADDR_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]    rs1_val, rs2_val, imm_val;
    logic signed [31:0] imm32;

    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [XLEN-1:0]    rs2_q, rs2_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]    imm_q, imm_d;

    logic               load_en, hazard;

    assign rs1 = RADDR_W'(instr_decode[19:15]);
    assign rs2 = RADDR_W'(instr_decode[24:20]);
    assign rd  = RADDR_W'(instr_decode[11:7]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && wb_addr != '0) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Writeback data is forwarded so an instruction decoded in the same cycle sees it.
    always_comb begin
        rs1_val = rf_q[rs1];
        if (rs1 == '0) begin
            rs1_val = '0;
        end else if (wb_en && wb_addr == rs1) begin
            rs1_val = wb_data;
        end
    end

    always_comb begin
        rs2_val = rf_q[rs2];
        if (rs2 == '0) begin
            rs2_val = '0;
        end else if (wb_en && wb_addr == rs2) begin
            rs2_val = wb_data;
        end
    end

    always_comb begin
        imm32 = '0;
        unique case (instr_decode[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm32 = {{20{instr_decode[31]}}, instr_decode[31:20]};
            OP_STORE:
                imm32 = {{20{instr_decode[31]}}, instr_decode[31:25], instr_decode[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr_decode[31]}}, instr_decode[31], instr_decode[7],
                         instr_decode[30:25], instr_decode[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr_decode[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr_decode[31]}}, instr_decode[31], instr_decode[19:12],
                         instr_decode[20], instr_decode[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_val = XLEN'(imm32);

    // Conservative: any rs field matching a pending load's rd stalls, whatever the opcode.
    assign load_en  = ~out_valid_q | out_ready;
    assign hazard   = out_valid_q && (instr_q[6:0] == OP_LOAD) && (rd_q != '0)
                      && ((rd_q == rs1) || (rd_q == rs2));
    assign in_ready = flush | (load_en & ~hazard);

    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        if (flush || (load_en && hazard)) begin
            out_valid_d = 1'b0;
            instr_d     = NOP_INSTR;
        end else if (load_en && in_valid) begin
            out_valid_d = 1'b1;
            pc_d        = pc_decode;
            instr_d     = instr_decode;
            rs1_d       = rs1_val;
            rs2_d       = rs2_val;
            rd_d        = rd;
            imm_d       = imm_val;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pc_exe    = pc_q;
    assign instr_exe = instr_q;
    assign rs1_exe   = rs1_q;
    assign rs2_exe   = rs2_q;
    assign rd_exe    = rd_q;
    assign imm_exe   = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of accepted instructions checked against the
// execute payload, plus directed checks of stall, bubble, flush and reset behaviour.
module tb_decode_stage;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM_C  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD_C = 7'b0000011;
    localparam logic [6:0]  OP_LUI_C  = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
    logic [31:0] pc_decode, instr_decode, wb_data;
    logic [31:0] pc_exe, instr_exe, rs1_exe, rs2_exe, imm_exe;
    logic [4:0]  wb_addr, rd_exe;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_decode    (pc_decode),
        .instr_decode (instr_decode),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc_exe       (pc_exe),
        .instr_exe    (instr_exe),
        .rs1_exe      (rs1_exe),
        .rs2_exe      (rs2_exe),
        .rd_exe       (rd_exe),
        .imm_exe      (imm_exe)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
    } pay_t;

    pay_t        sb_q[$];
    logic [31:0] rf_m [32];
    logic [31:0] exp_imm_cur;
    logic [31:0] pc_n;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] off, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {off[11:5], rs2, rs1, 3'b010, off[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf_m[a];
    endfunction

    // Monitor looks at the cycle about to be committed by the next rising edge.
    always @(negedge clk) begin : mon
        pay_t e;
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        end else begin
            if (out_valid && out_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc",    pc_exe,        e.pc);
                    chk("sb_instr", instr_exe,     e.instr);
                    chk("sb_rs1",   rs1_exe,       e.rs1);
                    chk("sb_rs2",   rs2_exe,       e.rs2);
                    chk("sb_imm",   imm_exe,       e.imm);
                    chk("sb_rd",    32'(rd_exe),   32'(e.rd));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                e.pc    = pc_decode;
                e.instr = instr_decode;
                e.rs1   = opnd(instr_decode[19:15]);
                e.rs2   = opnd(instr_decode[24:20]);
                e.imm   = exp_imm_cur;
                e.rd    = instr_decode[11:7];
                sb_q.push_back(e);
            end
            if (wb_en && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] imm);
        in_valid     = 1'b1;
        instr_decode = ins;
        pc_decode    = pc_n;
        exp_imm_cur  = imm;
        pc_n         = pc_n + 32'd4;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] imm);
        present(ins, imm);
        cyc(1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_pc"},    pc_exe,         32'd0);
        chk({tag, "_instr"}, instr_exe,      NOP);
        chk({tag, "_rs1"},   rs1_exe,        32'd0);
        chk({tag, "_rs2"},   rs2_exe,        32'd0);
        chk({tag, "_imm"},   imm_exe,        32'd0);
        chk({tag, "_rd"},    32'(rd_exe),    32'd0);
    endtask

    logic [31:0] ia, ib, iadd, pc_c;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_addr = 5'd0;
        wb_data = 32'd0; flush = 1'b0; pc_decode = 32'd0; instr_decode = NOP;
        exp_imm_cur = 32'd0; pc_n = 32'h0000_1000;
        cyc(2);
        check_reset("rst");
        rst = 1'b0;

        // writeback then read through the register file
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        cyc(1);
        wb_en = 1'b0;
        send(enc_r(7'h00, 5'd0, 5'd5, 5'd7), 32'd0);
        idle();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_rs1",   rs1_exe,        32'hDEAD_BEEF);
        chk("t1_rs2",   rs2_exe,        32'd0);
        chk("t1_rd",    32'(rd_exe),    32'd7);

        // same-cycle bypass, and x0 never bypassed
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_1234;
        send(enc_r(7'h20, 5'd3, 5'd3, 5'd1), 32'd0);
        chk("byp_rs1", rs1_exe, 32'h0000_1234);
        chk("byp_rs2", rs2_exe, 32'h0000_1234);
        wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
        send(enc_r(7'h00, 5'd0, 5'd0, 5'd2), 32'd0);
        wb_en = 1'b0;
        idle();
        chk("x0_rs1", rs1_exe, 32'd0);
        chk("x0_rs2", rs2_exe, 32'd0);

        // back-pressure stall for three cycles
        cyc(1);
        out_ready = 1'b0;
        ia = enc_i(12'd1, 5'd0, 3'b000, 5'd8, OP_IMM_C);
        send(ia, 32'd1);
        ib = enc_i(12'd2, 5'd0, 3'b000, 5'd10, OP_IMM_C);
        present(ib, 32'd2);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_rdy",  32'(in_ready),  32'd0);
            chk("stall_hold", instr_exe,      ia);
            chk("stall_vld",  32'(out_valid), 32'd1);
            cyc(1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_rdy", 32'(in_ready), 32'd1);
        cyc(1);
        idle();
        chk("release_cap", instr_exe, ib);

        // load-use bubble
        present(enc_i(12'd0, 5'd2, 3'b010, 5'd4, OP_LOAD_C), 32'd0);
        cyc(1);
        iadd = enc_r(7'h00, 5'd1, 5'd4, 5'd6);
        present(iadd, 32'd0);
        #1;
        chk("lu_stall", 32'(in_ready), 32'd0);
        cyc(1);
        chk("lu_bub_v", 32'(out_valid), 32'd0);
        chk("lu_bub_i", instr_exe,      NOP);
        chk("lu_rdy",   32'(in_ready),  32'd1);
        cyc(1);
        idle();
        chk("lu_cap_v", 32'(out_valid), 32'd1);
        chk("lu_cap_i", instr_exe,      iadd);

        // load to x0 never creates a hazard
        cyc(1);
        present(enc_i(12'd0, 5'd2, 3'b010, 5'd0, OP_LOAD_C), 32'd0);
        cyc(1);
        iadd = enc_r(7'h00, 5'd1, 5'd0, 5'd6);
        present(iadd, 32'd0);
        #1;
        chk("lu0_rdy", 32'(in_ready), 32'd1);
        cyc(1);
        idle();
        chk("lu0_v", 32'(out_valid), 32'd1);
        chk("lu0_i", instr_exe,      iadd);

        // immediates, back to back
        cyc(1);
        send(32'hFFF0_0093, 32'hFFFF_FFFF);
        chk("imm_addi", imm_exe, 32'hFFFF_FFFF);
        send(enc_b(13'h1FFC, 5'd0, 5'd0), 32'hFFFF_FFFC);
        chk("imm_beq", imm_exe, 32'hFFFF_FFFC);
        send({20'h12345, 5'd1, OP_LUI_C}, 32'h1234_5000);
        chk("imm_lui", imm_exe, 32'h1234_5000);
        send(enc_j(21'd2048, 5'd1), 32'h0000_0800);
        chk("imm_jal", imm_exe, 32'h0000_0800);
        send(enc_s(12'hFF8, 5'd2, 5'd5), 32'hFFFF_FFF8);
        idle();
        chk("imm_sw", imm_exe, 32'hFFFF_FFF8);

        // flush while stalled, with a concurrent writeback
        cyc(1);
        out_ready = 1'b0;
        pc_c = pc_n;
        send(enc_i(12'd3, 5'd0, 3'b000, 5'd11, OP_IMM_C), 32'd3);
        present(enc_i(12'd4, 5'd0, 3'b000, 5'd12, OP_IMM_C), 32'd4);
        flush = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5_0009;
        #1;
        chk("fl_rdy", 32'(in_ready), 32'd1);
        cyc(1);
        flush = 1'b0; wb_en = 1'b0;
        idle();
        chk("fl_v",       32'(out_valid), 32'd0);
        chk("fl_i",       instr_exe,      NOP);
        chk("fl_pc_hold", pc_exe,         pc_c);
        out_ready = 1'b1;
        send(enc_r(7'h00, 5'd0, 5'd9, 5'd12), 32'd0);
        idle();
        chk("x9_rd", rs1_exe, 32'hA5A5_0009);

        // reset in the middle of a stalled transfer
        cyc(1);
        out_ready = 1'b0;
        send(enc_i(12'hFFB, 5'd9, 3'b000, 5'd14, OP_IMM_C), 32'hFFFF_FFFB);
        present(enc_r(7'h00, 5'd0, 5'd0, 5'd15), 32'd0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        idle();
        check_reset("mid_rst");
        out_ready = 1'b1;
        send(enc_r(7'h00, 5'd9, 5'd5, 5'd13), 32'd0);
        idle();
        chk("rf_clr_rs1", rs1_exe, 32'd0);
        chk("rf_clr_rs2", rs2_exe, 32'd0);

        cyc(3);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised RISC-V decode pipeline stage, placed between fetch and execute.
- Holds the architectural register file, with write-before-read bypass from writeback.
- Generates a sign-extended immediate for the instruction.
- Registers a full decode-to-execute payload under a valid/ready handshake, with stall, flush and load-use bubble insertion.

Parameters:
- XLEN, 32, data and PC width in bits.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- RADDR_W, $clog2(NREGS), register address width.
- NOP_INSTR, 32'h00000013, encoding written to instr_exe for a bubble (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  stage accepts the fetch payload this cycle.
- pc_decode  in  XLEN  PC of the incoming instruction.
- instr_decode  in  32  incoming instruction.
- wb_en  in  1  writeback write enable.
- wb_addr  in  RADDR_W  writeback destination register.
- wb_data  in  XLEN  writeback data.
- flush  in  1  squash the in-flight decode and execute-input contents (branch redirect).
- out_valid  out  1  execute payload is valid.
- out_ready  in  1  execute consumes the payload this cycle.
- pc_exe  out  XLEN  registered PC.
- instr_exe  out  32  registered instruction.
- rs1_exe  out  XLEN  registered rs1 operand.
- rs2_exe  out  XLEN  registered rs2 operand.
- rd_exe  out  RADDR_W  registered instr[11:7], truncated to RADDR_W.
- imm_exe  out  XLEN  registered sign-extended immediate.

Behaviour:
- Reset: one clock, synchronous, active-high (clk, rst); both polarity and synchronicity are fixed.
- Output values during and after reset: out_valid=0, pc_exe=0, instr_exe=NOP_INSTR, rs1_exe=rs2_exe=imm_exe=0, rd_exe=0.
- Register file is cleared to 0 by reset.
- Reset mid-operation discards all payload; the first accept after reset is the cycle following deassertion.
- Register file:
  - Written on the clk edge when wb_en=1 and wb_addr!=0; writes to x0 are ignored.
  - Reads are combinational on rs1=instr_decode[19:15] and rs2=instr_decode[24:20], truncated to RADDR_W.
  - Read of x0 returns 0.
  - Bypass: if wb_en=1, wb_addr==rs and rs!=0, the read returns wb_data in the same cycle.
- Immediate, selected by opcode instr[6:0], sign bit instr[31]:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: 0.
- Handshake:
  - load_en = ~out_valid | out_ready.
  - Load-use hazard = out_valid & (instr_exe[6:0]==0000011) & rd_exe!=0 & (rd_exe==rs1 | rd_exe==rs2). Comparison is conservative and independent of the incoming opcode.
  - in_ready = flush | (load_en & ~hazard).
- Per-cycle priority:
  1. flush=1: output register becomes a bubble (out_valid=0, instr_exe=NOP_INSTR, other fields hold). The incoming instruction is accepted and dropped. Register-file write still occurs.
  2. load_en & hazard: bubble inserted (out_valid=0, instr_exe=NOP_INSTR); input is held (in_ready=0). The next cycle re-evaluates, with the hazard now cleared.
  3. load_en & in_valid: capture PC, instruction, operands (bypassed), rd and immediate; out_valid=1. Latency is 1 cycle from accept to out_valid.
  4. load_en & ~in_valid: out_valid=0, other fields hold.
  5. ~load_en (stall): all outputs hold; in_ready=0.
- Operands are sampled only at capture. A writeback landing while the payload is stalled in the output register is not re-forwarded; execute-stage forwarding covers that case.
- Handshake assumptions:
  - Upstream holds pc_decode and instr_decode stable while in_valid & ~in_ready.
  - While out_valid=1 and out_ready=0, the payload is stable.

Test Plan:
- Reset, then write x5=0xDEADBEEF via wb; next cycle present add x7,x5,x0 with out_ready=1 -> out_valid=1 after 1 cycle, rs1_exe=0xDEADBEEF, rs2_exe=0, rd_exe=7.
- Same-cycle bypass: wb_en=1, wb_addr=3, wb_data=0x1234 while decoding sub x1,x3,x3 -> rs1_exe=rs2_exe=0x1234. wb_addr=0, wb_data=0xFFFF while decoding a read of x0 -> operand 0.
- Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable for 3 cycles; release -> next instruction captured on the first ready cycle, none lost or duplicated.
- Load-use: lw x4,0(x2) accepted, then add x6,x4,x1 with out_ready=1 -> one bubble (out_valid=0, instr_exe=0x00000013), add appears the following cycle. Same test using lw x0 -> no bubble.
- Immediates: instr 0xFFF00093 (addi -1) -> imm_exe=0xFFFFFFFF; beq with offset -4 -> 0xFFFFFFFC; lui 0x12345 -> 0x12345000; jal +2048 -> 0x00000800.
- Flush during stall (out_valid=1, out_ready=0, flush=1) with a concurrent wb to x9 -> out_valid=0 next cycle, in_ready=1, x9 updated. Assert rst mid-stream -> all outputs at reset values next cycle.
